apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master.sv | 162 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB command master: takes one command at a time from a valid/ready command
// port, runs it as a single APB transfer (SETUP then ACCESS with wait states),
// and returns the read data and completion status on a valid/ready response port.
// A wait counter aborts transfers whose responder never asserts pready.
module apb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        pclk,
  input  logic        presetn,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  // APB initiator
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  // counter value during the final permitted ACCESS cycle
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_MAX  = CW'(TIMEOUT_CYCLES);

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_SLV     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t        state_q,     state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          psel_q,      psel_d;
  logic          penable_q,   penable_d;
  logic          pwrite_q,    pwrite_d;
  logic [31:0]   paddr_q,     paddr_d;
  logic [31:0]   pwdata_q,    pwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_err_q,   rsp_err_d;
  logic [CW-1:0] wait_cnt_q,  wait_cnt_d;

  // Next state, transfer capture, completion/timeout decode; all outputs are
  // derived from the next state so they come straight off flops.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d  = ST_SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr & ADDR_MASK;
          pwdata_d = cmd_wdata;
        end
      end

      ST_SETUP: begin
        state_d    = ST_ACCESS;
        wait_cnt_d = '0;
      end

      ST_ACCESS: begin
        if (pready) begin
          // a responder finishing on the last permitted cycle still wins
          state_d     = ST_RESP;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr ? ERR_SLV : ERR_OK;
        end else begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
          if (wait_cnt_q == WAIT_LAST) begin
            state_d     = ST_RESP;
            rsp_rdata_d = '0;
            rsp_err_d   = ERR_TIMEOUT;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and registered outputs; reset drops any transfer in flight.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master with a short timeout: directed vector table,
// reset and back-to-back sequences, then random transfers checked against
// an outcome model.
module tb_apb_cmd_master;

  localparam int T = 4;

  logic        pclk;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int total = 0;
  int bad   = 0;

  apb_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nwait;
    logic        se;
    logic [31:0] prd;
    int          hold;
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    int          e_acc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Outcome of one transfer from the rules: timeout after T waiting cycles,
  // otherwise nwait wait states then completion with slave status.
  function automatic void model(input logic w, input int nwait, input logic se,
                                input logic [31:0] prd, output logic [1:0] err,
                                output logic [31:0] rd, output int acc);
    if (nwait >= T) begin
      err = 2'b10; rd = 32'h0; acc = T;
    end else begin
      err = se ? 2'b01 : 2'b00;
      rd  = w ? 32'h0 : prd;
      acc = nwait + 1;
    end
  endfunction

  // Runs one command starting from an IDLE negedge; ends on an IDLE negedge.
  task automatic run_txn(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input int nwait, input logic se,
                         input logic [31:0] prd, input int hold, input logic [1:0] e_err,
                         input logic [31:0] e_rd, input int e_acc);
    int acc;
    logic [31:0] pa;
    pa = a & 32'hFFFF_FFFC;
    chk({tag, ".idle_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    chk({tag, ".setup_ctl"}, 32'({cmd_ready, psel, penable}), 32'b010);
    chk({tag, ".setup_addr"}, paddr, pa);
    chk({tag, ".setup_wr"}, 32'(pwrite), 32'(w));
    chk({tag, ".setup_wdata"}, pwdata, wd);
    @(negedge pclk);
    acc = 0;
    while (psel && penable && acc < 40) begin
      acc++;
      chk({tag, ".acc_addr"}, paddr, pa);
      chk({tag, ".acc_wdata"}, pwdata, wd);
      if (acc == nwait + 1) begin
        pready = 1'b1; pslverr = se; prdata = prd;
      end else begin
        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
      end
      @(negedge pclk);
    end
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    chk({tag, ".access_cycles"}, 32'(acc), 32'(e_acc));
    chk({tag, ".resp_ctl"}, 32'({psel, penable, rsp_valid, cmd_ready}), 32'b0010);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(e_err));
    chk({tag, ".rsp_rdata"}, rsp_rdata, e_rd);
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge pclk);
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      chk({tag, ".hold_ctl"}, 32'({psel, penable, rsp_valid, cmd_ready}), 32'b0010);
      chk({tag, ".hold_err"}, 32'(rsp_err), 32'(e_err));
      chk({tag, ".hold_rdata"}, rsp_rdata, e_rd);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
    chk({tag, ".back_idle"}, 32'({psel, rsp_valid, cmd_ready}), 32'b001);
  endtask

  vec_t vecs [8];

  initial begin
    logic [1:0]  m_err;
    logic [31:0] m_rd;
    int          m_acc;
    int          setups, last_setup, gaps_bad, overlap;

    vecs[0] = '{1'b1, 32'h04, 32'h0000_00A5, 0,  1'b0, 32'h0,         0, 2'b00, 32'h0,         1};
    vecs[1] = '{1'b0, 32'h08, 32'h0,         3,  1'b0, 32'h0000_003C, 0, 2'b00, 32'h0000_003C, 4};
    vecs[2] = '{1'b0, 32'h10, 32'h0,         4,  1'b0, 32'h1111_1111, 1, 2'b10, 32'h0,         4};
    vecs[3] = '{1'b1, 32'h14, 32'h5A5A_5A5A, 3,  1'b1, 32'hFFFF_FFFF, 0, 2'b01, 32'h0,         4};
    vecs[4] = '{1'b1, 32'h20, 32'h0BAD_F00D, 0,  1'b1, 32'h0,         5, 2'b01, 32'h0,         1};
    vecs[5] = '{1'b0, 32'h07, 32'h0,         0,  1'b0, 32'hDEAD_BEEF, 0, 2'b00, 32'hDEAD_BEEF, 1};
    vecs[6] = '{1'b0, 32'h2E, 32'h0,         1,  1'b1, 32'h1234_5678, 2, 2'b01, 32'h1234_5678, 2};
    vecs[7] = '{1'b1, 32'h40, 32'hC0FF_EE00, 10, 1'b0, 32'h0,         0, 2'b10, 32'h0,         4};

    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // reset state
    repeat (2) @(negedge pclk);
    chk("rst.ctl", 32'({cmd_ready, psel, penable, pwrite, rsp_valid}), 32'b0);
    chk("rst.paddr", paddr, 32'h0);
    chk("rst.pwdata", pwdata, 32'h0);
    chk("rst.rsp", {rsp_rdata[29:0], rsp_err}, 32'h0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rst.ready_after", 32'(cmd_ready), 32'd1);

    // directed table
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].nwait,
              vecs[i].se, vecs[i].prd, vecs[i].hold, vecs[i].e_err, vecs[i].e_rd, vecs[i].e_acc);
    end

    // back-to-back: one transfer every 4 cycles, no overlap
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h77;
    pready = 1'b1; rsp_ready = 1'b1;
    setups = 0; last_setup = -3; gaps_bad = 0; overlap = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge pclk);
      if (psel && !penable) begin
        setups++;
        if (c - last_setup != 4) gaps_bad++;
        last_setup = c;
      end
      if (psel && rsp_valid) overlap++;
    end
    cmd_valid = 1'b0; pready = 1'b0; rsp_ready = 1'b0;
    chk("b2b.setups", 32'(setups), 32'd5);
    chk("b2b.gaps", 32'(gaps_bad), 32'd0);
    chk("b2b.overlap", 32'(overlap), 32'd0);
    chk("b2b.end_idle", 32'(cmd_ready), 32'd1);

    // reset during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'hABCD;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("mid.in_access", 32'({psel, penable}), 32'b11);
    #2 presetn = 1'b0;
    #1;
    chk("mid.ctl", 32'({psel, penable, rsp_valid, cmd_ready, pwrite}), 32'b0);
    chk("mid.paddr", paddr, 32'h0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("mid.after", 32'({cmd_ready, psel, rsp_valid}), 32'b100);
    run_txn("mid.read", 1'b0, 32'h30, 32'h0, 1, 1'b0, 32'hCAFE_0001, 0, 2'b00, 32'hCAFE_0001, 2);

    // random transfers against the outcome model
    for (int i = 0; i < 24; i++) begin
      logic        w, se;
      logic [31:0] a, wd, prd;
      int          nw, hd;
      w = 1'($urandom); se = 1'($urandom); a = $urandom; wd = $urandom; prd = $urandom;
      nw = int'($urandom_range(0, 5)); hd = int'($urandom_range(0, 2));
      model(w, nw, se, prd, m_err, m_rd, m_acc);
      run_txn($sformatf("rnd%0d", i), w, a, wd, nw, se, prd, hd, m_err, m_rd, m_acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
